// File: rtl/md_sequencer_if.sv
// md_sequencer_if
//   Handshake/bus bundle between the EX stage and the multiply/divide
//   sequencer.
//
//   The EX stage presents an op with md_valid and the decoded md_op.
//   rs_data and rt_data are the operands, and abort flushes the op.
//
//   The sequencer answers with the following:
//     - md_stall holds IF/ID/EX.
//     - md_busy is high while the sequencer is not idle.
//     - md_result and md_result_valid carry the GPR write data.
//     - hi and lo are the architectural HI/LO registers.
//     - md_state is the FSM state, exposed for debug.
//
//   Handshake: an op transfers on a rising clk edge when md_valid=1,
//   abort=0 and the sequencer is IDLE. While md_stall=1 the EX stage must
//   hold md_valid/md_op/rs_data/rt_data stable. md_result is only
//   meaningful in a cycle where md_result_valid=1.
//
//   Modports:
//     master : pipeline side (drives the request, abort)
//     slave  : sequencer side (drives stall/busy/result/hi/lo/state)
interface md_sequencer_if;
  logic        md_valid;
  logic [3:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        abort;
  logic        md_stall;
  logic        md_busy;
  logic [31:0] md_result;
  logic        md_result_valid;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [2:0]  md_state;

  modport master (
    output md_valid, md_op, rs_data, rt_data, abort,
    input  md_stall, md_busy, md_result, md_result_valid, hi, lo, md_state
  );

  modport slave (
    input  md_valid, md_op, rs_data, rt_data, abort,
    output md_stall, md_busy, md_result, md_result_valid, hi, lo, md_state
  );
endinterface

// File: rtl/md_sequencer.sv
// md_sequencer
//   Multi-cycle sequencer for the multiply/divide unit. It accepts one
//   MD op at a time and owns HI/LO.
//
//   Execution:
//     - Multiplies wait out a MUL_LAT-cycle multiplier.
//     - Divides run a 32-step restoring divider followed by one sign-fix
//       cycle.
//     - MTHI/MTLO/MFHI/MFLO complete in IDLE without stalling.
//     - MUL (GPR-destination multiply) returns product[31:0] in DONE and
//       leaves HI/LO untouched.
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     md     md_sequencer_if.slave. Carries the request
//            (md_valid/md_op/rs_data/rt_data/abort) and the response
//            (md_stall/md_busy/md_result/md_result_valid/hi/lo/md_state).
//
//   Parameters:
//     MUL_LAT    cycles from accept to product available, 1..4
//     DIV_STEPS  divider iterations, equal to the operand width (32)
module md_sequencer #(
  parameter int MUL_LAT   = 2,
  parameter int DIV_STEPS = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  md_sequencer_if.slave md
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MUL   = 4'd9;

  // Counters load "remaining cycles - 1" and the last cycle sees zero.
  localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_LAT - 1);
  localparam logic [4:0] DIV_CNT_INIT = 5'(DIV_STEPS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL_WAIT = 3'd1,
    DIV_RUN  = 3'd2,
    DIV_FIX  = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic        mul_pending_q;
  // op_a_q holds the multiplicand, or the dividend/quotient shift
  // register while dividing. op_b_q holds the multiplier or |divisor|.
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic [31:0] rem_q;
  logic        op_signed_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        issue;
  logic        div_signed;
  logic [31:0] rs_abs;
  logic [31:0] rt_abs;
  logic [63:0] mul_a_ext;
  logic [63:0] mul_b_ext;
  logic [63:0] product;
  logic [32:0] rem_sh;
  logic [32:0] rem_diff;

  logic        stall_c;
  logic        result_valid_c;
  logic [31:0] result_c;

  assign issue = md.md_valid && !md.abort;

  // Divide operand magnitudes. DIVU passes the raw values through.
  assign div_signed = (md.md_op == OP_DIV);
  assign rs_abs = (div_signed && md.rs_data[31]) ? (~md.rs_data + 32'd1) : md.rs_data;
  assign rt_abs = (div_signed && md.rt_data[31]) ? (~md.rt_data + 32'd1) : md.rt_data;

  // The low 64 bits of the product of sign- or zero-extended operands are
  // the exact signed/unsigned 64-bit product.
  assign mul_a_ext = {{32{op_signed_q & op_a_q[31]}}, op_a_q};
  assign mul_b_ext = {{32{op_signed_q & op_b_q[31]}}, op_b_q};
  assign product   = mul_a_ext * mul_b_ext;

  // Restoring step: shift the next dividend bit into the partial
  // remainder and try to subtract the divisor.
  //   - A clear bit 32 of rem_diff means the subtraction fits.
  //   - rem_sh cannot reach 2^32 within 32 steps, because rem_q starts at
  //     zero.
  //   - With a zero divisor every step therefore succeeds. The result is
  //     an all-ones quotient and a remainder equal to the dividend.
  assign rem_sh   = {rem_q, op_a_q[31]};
  assign rem_diff = rem_sh - {1'b0, op_b_q};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and outputs
  always_comb begin
    state_d        = state_q;
    stall_c        = 1'b0;
    result_valid_c = 1'b0;
    result_c       = 32'd0;

    case (state_q)
      IDLE: begin
        // MUL stalls from its own issue cycle so the dependent GPR write
        // lines up with DONE.
        stall_c = md.md_valid && (md.md_op == OP_MUL);
        if (issue) begin
          case (md.md_op)
            OP_MULT, OP_MULTU, OP_MUL: state_d = MUL_WAIT;
            OP_DIV, OP_DIVU:           state_d = DIV_RUN;
            OP_MFHI: begin
              result_valid_c = 1'b1;
              result_c       = hi_q;
            end
            OP_MFLO: begin
              result_valid_c = 1'b1;
              result_c       = lo_q;
            end
            default: ;
          endcase
        end
      end

      MUL_WAIT: begin
        stall_c = md.md_valid;
        if (md.abort) begin
          state_d = IDLE;
        end else if (cnt_q == 5'd0) begin
          state_d = DONE;
        end
      end

      DIV_RUN: begin
        stall_c = md.md_valid;
        if (md.abort) begin
          state_d = IDLE;
        end else if (cnt_q == 5'd0) begin
          state_d = DIV_FIX;
        end
      end

      DIV_FIX: begin
        stall_c = md.md_valid;
        state_d = md.abort ? IDLE : DONE;
      end

      DONE: begin
        // The completing MUL is released here. Any other MD op waits one
        // more cycle so that it sees the new HI/LO in IDLE.
        stall_c = md.md_valid && !mul_pending_q;
        state_d = IDLE;
        if (mul_pending_q && !md.abort) begin
          result_valid_c = 1'b1;
          result_c       = product[31:0];
        end
      end

      default: state_d = IDLE;
    endcase

    if (md.abort) begin
      stall_c = 1'b0;
    end
  end

  // Datapath and architectural HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= 5'd0;
      mul_pending_q <= 1'b0;
      op_a_q        <= 32'd0;
      op_b_q        <= 32'd0;
      rem_q         <= 32'd0;
      op_signed_q   <= 1'b0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      hi_q          <= 32'd0;
      lo_q          <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue) begin
            case (md.md_op)
              OP_MTHI: hi_q <= md.rs_data;
              OP_MTLO: lo_q <= md.rs_data;
              OP_MULT, OP_MULTU, OP_MUL: begin
                op_a_q        <= md.rs_data;
                op_b_q        <= md.rt_data;
                op_signed_q   <= (md.md_op != OP_MULTU);
                mul_pending_q <= (md.md_op == OP_MUL);
                cnt_q         <= MUL_CNT_INIT;
              end
              OP_DIV, OP_DIVU: begin
                op_a_q      <= rs_abs;
                op_b_q      <= rt_abs;
                rem_q       <= 32'd0;
                op_signed_q <= div_signed;
                neg_quo_q   <= div_signed && (md.rs_data[31] ^ md.rt_data[31]);
                neg_rem_q   <= div_signed && md.rs_data[31];
                cnt_q       <= DIV_CNT_INIT;
              end
              default: ;
            endcase
          end
        end

        MUL_WAIT: begin
          if (!md.abort) begin
            if (cnt_q == 5'd0) begin
              if (!mul_pending_q) begin
                hi_q <= product[63:32];
                lo_q <= product[31:0];
              end
            end else begin
              cnt_q <= cnt_q - 5'd1;
            end
          end
        end

        DIV_RUN: begin
          if (!md.abort) begin
            if (!rem_diff[32]) begin
              rem_q  <= rem_diff[31:0];
              op_a_q <= {op_a_q[30:0], 1'b1};
            end else begin
              rem_q  <= rem_sh[31:0];
              op_a_q <= {op_a_q[30:0], 1'b0};
            end
            if (cnt_q != 5'd0) begin
              cnt_q <= cnt_q - 5'd1;
            end
          end
        end

        DIV_FIX: begin
          if (!md.abort) begin
            lo_q <= neg_quo_q ? (~op_a_q + 32'd1) : op_a_q;
            hi_q <= neg_rem_q ? (~rem_q + 32'd1) : rem_q;
          end
        end

        DONE: mul_pending_q <= 1'b0;

        default: ;
      endcase

      if (md.abort) begin
        mul_pending_q <= 1'b0;
      end
    end
  end

  assign md.md_stall        = stall_c;
  assign md.md_busy         = (state_q != IDLE);
  assign md.md_result       = result_c;
  assign md.md_result_valid = result_valid_c;
  assign md.hi              = hi_q;
  assign md.lo              = lo_q;
  assign md.md_state        = state_q;

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer
//   Directed bench for md_sequencer with MUL_LAT=2. A cycle-by-cycle
//   vector table covers the following:
//     - MTHI/MTLO/MFHI/MFLO
//     - MULT/MULTU/MUL timing and stalls
//     - aborts and illegal ops
//   Hand-written sequences cover these cases:
//     - divide latency and results
//     - MFLO waiting on a divide
//     - abort mid-divide
//     - reset mid-multiply
module tb_md_sequencer;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MUL   = 4'd9;
  localparam logic [3:0] OP_BAD   = 4'd15;

  typedef struct {
    string       name;
    logic        v;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        ab;
    logic        st;
    logic        bz;
    logic        rv;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic clk;
  logic rst_n;
  md_sequencer_if bus();

  md_sequencer #(.MUL_LAT(2), .DIV_STEPS(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .md   (bus)
  );

  vec_t        vecs[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic ab);
    bus.md_valid = v;
    bus.md_op    = op;
    bus.rs_data  = rs;
    bus.rt_data  = rt;
    bus.abort    = ab;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input logic v, input logic [3:0] op,
                     input logic [31:0] rs, input logic [31:0] rt, input logic ab,
                     input logic st, input logic bz, input logic rv,
                     input logic [31:0] res, input logic [31:0] hi, input logic [31:0] lo);
    vec_t r;
    r.name = n; r.v = v; r.op = op; r.rs = rs; r.rt = rt; r.ab = ab;
    r.st = st; r.bz = bz; r.rv = rv; r.res = res; r.hi = hi; r.lo = lo;
    vecs.push_back(r);
  endtask

  // Scoreboard compare. md_result is compared only where it is required.
  task automatic check(input string n, input logic st, input logic bz, input logic rv,
                       input logic chk_res, input logic [31:0] res,
                       input logic [31:0] hi, input logic [31:0] lo);
    n_vec++;
    if (bus.md_stall !== st || bus.md_busy !== bz || bus.md_result_valid !== rv ||
        (chk_res && bus.md_result !== res) || bus.hi !== hi || bus.lo !== lo) begin
      n_miss++;
      $display("FAIL %s: got stall=%b busy=%b rv=%b res=%h hi=%h lo=%h, want stall=%b busy=%b rv=%b res=%h hi=%h lo=%h",
               n, bus.md_stall, bus.md_busy, bus.md_result_valid, bus.md_result, bus.hi, bus.lo,
               st, bz, rv, res, hi, lo);
    end
  endtask

  // Issue a divide and follow it through 33 busy cycles, DONE and IDLE.
  task automatic run_div(input string n, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int bad;
    drive(1'b1, op, a, b, 1'b0);
    @(negedge clk);
    check({n, "_issue"}, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, cur_hi, cur_lo);
    next_cycle();
    drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    bad = 0;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      if (bus.md_busy !== 1'b1 || bus.md_stall !== 1'b0 || bus.md_result_valid !== 1'b0 ||
          bus.hi !== cur_hi || bus.lo !== cur_lo) bad++;
      next_cycle();
    end
    n_vec++;
    if (bad != 0) begin
      n_miss++;
      $display("FAIL %s_busy: %0d of 33 busy cycles wrong, want busy=1 with hi=%h lo=%h held",
               n, bad, cur_hi, cur_lo);
    end
    @(negedge clk);
    check({n, "_done"}, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, eh, el);
    next_cycle();
    @(negedge clk);
    check({n, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, eh, el);
    next_cycle();
    cur_hi = eh;
    cur_lo = el;
  endtask

  initial begin
    int bad;

    // Vector table: one row per clock cycle, with outputs as seen before
    // the closing edge.
    //      name                  v  op        rs            rt            ab st bz rv res           hi            lo
    add("idle",                 0, OP_NONE,  32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        32'h0);
    add("mthi_issue",           1, OP_MTHI,  32'h1234,     32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        32'h0);
    add("mfhi",                 1, OP_MFHI,  32'h0,        32'h0,        0, 0, 0, 1, 32'h1234,     32'h1234,     32'h0);
    add("mtlo_issue",           1, OP_MTLO,  32'hCAFEF00D, 32'h0,        0, 0, 0, 0, 32'h0,        32'h1234,     32'h0);
    add("mflo",                 1, OP_MFLO,  32'h0,        32'h0,        0, 0, 0, 1, 32'hCAFEF00D, 32'h1234,     32'hCAFEF00D);
    add("mult_issue",           1, OP_MULT,  32'hFFFFFFFE, 32'h3,        0, 0, 0, 0, 32'h0,        32'h1234,     32'hCAFEF00D);
    add("mult_wait1",           0, OP_NONE,  32'h0,        32'h0,        0, 0, 1, 0, 32'h0,        32'h1234,     32'hCAFEF00D);
    add("mult_wait2",           0, OP_NONE,  32'h0,        32'h0,        0, 0, 1, 0, 32'h0,        32'h1234,     32'hCAFEF00D);
    add("mult_done",            0, OP_NONE,  32'h0,        32'h0,        0, 0, 1, 0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA);
    add("mult_idle",            0, OP_NONE,  32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA);
    add("multu_issue",          1, OP_MULTU, 32'hFFFFFFFE, 32'h3,        0, 0, 0, 0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA);
    add("multu_wait1_mfhi",     1, OP_MFHI,  32'h0,        32'h0,        0, 1, 1, 0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA);
    add("multu_wait2_mfhi",     1, OP_MFHI,  32'h0,        32'h0,        0, 1, 1, 0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA);
    add("multu_done_mfhi",      1, OP_MFHI,  32'h0,        32'h0,        0, 1, 1, 0, 32'h0,        32'h2,        32'hFFFFFFFA);
    add("mfhi_after_multu",     1, OP_MFHI,  32'h0,        32'h0,        0, 0, 0, 1, 32'h2,        32'h2,        32'hFFFFFFFA);
    add("mul_issue",            1, OP_MUL,   32'h6,        32'h7,        0, 1, 0, 0, 32'h0,        32'h2,        32'hFFFFFFFA);
    add("mul_wait1",            1, OP_MUL,   32'h6,        32'h7,        0, 1, 1, 0, 32'h0,        32'h2,        32'hFFFFFFFA);
    add("mul_wait2",            1, OP_MUL,   32'h6,        32'h7,        0, 1, 1, 0, 32'h0,        32'h2,        32'hFFFFFFFA);
    add("mul_done",             1, OP_MUL,   32'h6,        32'h7,        0, 0, 1, 1, 32'd42,       32'h2,        32'hFFFFFFFA);
    add("mul_idle",             0, OP_NONE,  32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        32'h2,        32'hFFFFFFFA);
    add("abort_idle_mthi",      1, OP_MTHI,  32'hDEAD,     32'h0,        1, 0, 0, 0, 32'h0,        32'h2,        32'hFFFFFFFA);
    add("mfhi_no_write",        1, OP_MFHI,  32'h0,        32'h0,        0, 0, 0, 1, 32'h2,        32'h2,        32'hFFFFFFFA);
    add("bad_op",               1, OP_BAD,   32'h55,       32'h66,       0, 0, 0, 0, 32'h0,        32'h2,        32'hFFFFFFFA);
    add("bad_op_after",         0, OP_NONE,  32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        32'h2,        32'hFFFFFFFA);
    add("abort_mul_issue",      1, OP_MUL,   32'h6,        32'h7,        1, 0, 0, 0, 32'h0,        32'h2,        32'hFFFFFFFA);
    add("abort_mul_after",      0, OP_NONE,  32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        32'h2,        32'hFFFFFFFA);
    add("mult_neg_issue",       1, OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 32'h0,        32'h2,        32'hFFFFFFFA);
    add("mult_neg_wait1",       0, OP_NONE,  32'h0,        32'h0,        0, 0, 1, 0, 32'h0,        32'h2,        32'hFFFFFFFA);
    add("mult_neg_wait2",       0, OP_NONE,  32'h0,        32'h0,        0, 0, 1, 0, 32'h0,        32'h2,        32'hFFFFFFFA);
    add("mult_neg_done",        0, OP_NONE,  32'h0,        32'h0,        0, 0, 1, 0, 32'h0,        32'h0,        32'h1);
    add("mult_neg_idle",        0, OP_NONE,  32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        32'h1);
    add("multu_ab_issue",       1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 32'h0,        32'h0,        32'h1);
    add("multu_ab_wait1",       0, OP_NONE,  32'h0,        32'h0,        0, 0, 1, 0, 32'h0,        32'h0,        32'h1);
    add("multu_ab_final_abort", 1, OP_MFLO,  32'h0,        32'h0,        1, 0, 1, 0, 32'h0,        32'h0,        32'h1);
    add("multu_ab_after",       0, OP_NONE,  32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        32'h1);
    add("mult_dab_issue",       1, OP_MULT,  32'h3,        32'h5,        0, 0, 0, 0, 32'h0,        32'h0,        32'h1);
    add("mult_dab_wait1",       0, OP_NONE,  32'h0,        32'h0,        0, 0, 1, 0, 32'h0,        32'h0,        32'h1);
    add("mult_dab_wait2",       0, OP_NONE,  32'h0,        32'h0,        0, 0, 1, 0, 32'h0,        32'h0,        32'h1);
    add("mult_done_abort",      0, OP_NONE,  32'h0,        32'h0,        1, 0, 1, 0, 32'h0,        32'h0,        32'hF);
    add("mult_dab_idle",        0, OP_NONE,  32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        32'hF);

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset", 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
    rst_n = 1'b1;
    next_cycle();

    // Table
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].ab);
      @(negedge clk);
      check(vecs[i].name, vecs[i].st, vecs[i].bz, vecs[i].rv, vecs[i].rv,
            vecs[i].res, vecs[i].hi, vecs[i].lo);
      next_cycle();
    end
    drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    cur_hi = 32'h0;
    cur_lo = 32'hF;

    // Divides
    run_div("div_m7_2",    OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_div("divu_m7_2",   OP_DIVU, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC);
    run_div("divu_5_0",    OP_DIVU, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF);
    run_div("div_ovf",     OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_div("div_100_m7",  OP_DIV,  32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2);
    run_div("div_m5_0",    OP_DIV,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'h00000001);

    // MFLO presented five cycles after a divide issues
    drive(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    check("mflo_dep_issue", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, cur_hi, cur_lo);
    next_cycle();
    drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    repeat (4) next_cycle();
    drive(1'b1, OP_MFLO, 32'd0, 32'd0, 1'b0);
    bad = 0;
    for (int c = 5; c <= 34; c++) begin
      @(negedge clk);
      if (bus.md_stall !== 1'b1 || bus.md_busy !== 1'b1 || bus.md_result_valid !== 1'b0) bad++;
      next_cycle();
    end
    n_vec++;
    if (bad != 0) begin
      n_miss++;
      $display("FAIL mflo_dep_stall: %0d of 30 cycles wrong, want stall=1 busy=1 rv=0", bad);
    end
    @(negedge clk);
    check("mflo_dep_result", 1'b0, 1'b0, 1'b1, 1'b1, 32'd14, 32'd2, 32'd14);
    next_cycle();
    drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    cur_hi = 32'd2;
    cur_lo = 32'd14;

    // Abort on cycle 10 of a divide
    drive(1'b1, OP_DIV, 32'd1000, 32'd3, 1'b0);
    @(negedge clk);
    check("div_abort_issue", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, cur_hi, cur_lo);
    next_cycle();
    drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    repeat (9) next_cycle();
    drive(1'b1, OP_MFHI, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    check("div_abort_c10", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, cur_hi, cur_lo);
    next_cycle();
    drive(1'b1, OP_MFHI, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("div_abort_mfhi", 1'b0, 1'b0, 1'b1, 1'b1, cur_hi, cur_hi, cur_lo);
    next_cycle();
    drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);

    // Reset in the middle of a MULT
    drive(1'b1, OP_MULT, 32'd3, 32'd5, 1'b0);
    @(negedge clk);
    check("rst_mult_issue", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, cur_hi, cur_lo);
    next_cycle();
    drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("rst_mult_wait", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, cur_hi, cur_lo);
    #1 rst_n = 1'b0;
    #1 check("rst_mid_mult", 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_after", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
